// File: rtl/keypad_pkg.sv
// Shared keypad definitions: idle vector, key bit indices and matrix-position helpers.
// Also imported by the lock block for its secret-number constants.
package keypad_pkg;

  localparam logic [11:0] KEY_IDLE = 12'hFFF;

  localparam logic [3:0] KEY_1    = 4'd0;
  localparam logic [3:0] KEY_2    = 4'd1;
  localparam logic [3:0] KEY_3    = 4'd2;
  localparam logic [3:0] KEY_4    = 4'd3;
  localparam logic [3:0] KEY_5    = 4'd4;
  localparam logic [3:0] KEY_6    = 4'd5;
  localparam logic [3:0] KEY_7    = 4'd6;
  localparam logic [3:0] KEY_8    = 4'd7;
  localparam logic [3:0] KEY_9    = 4'd8;
  localparam logic [3:0] KEY_0    = 4'd9;
  localparam logic [3:0] KEY_HASH = 4'd10;
  localparam logic [3:0] KEY_STAR = 4'd11;

  typedef enum logic [1:0] {
    COL0 = 2'd0,
    COL1 = 2'd1,
    COL2 = 2'd2
  } col_state_e;

  // Rows 0..2 hold digits 1..9 in reading order; row 3 is '*', '0', '#'.
  function automatic logic [3:0] key_index(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] idx;
    if (row == 2'd3) begin
      case (col)
        2'd0:    idx = KEY_STAR;
        2'd1:    idx = KEY_0;
        default: idx = KEY_HASH;
      endcase
    end else begin
      idx = ({2'b00, row} * 4'd3) + {2'b00, col};
    end
    return idx;
  endfunction

  function automatic logic single_key(input logic [11:0] v);
    return $countones(~v) == 1;
  endfunction

endpackage

// File: rtl/kp_sync2.sv
// Two-flop synchronizer for the asynchronous row lines; resets to the idle level.
module kp_sync2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 4'hF;
      q      <= 4'hF;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x3 key matrix scanner: column strobing, frame snapshot, frame-level debounce
// and chord rejection, producing an active-low one-hot key vector.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int DB_CNT   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  row_n,
  output logic [2:0]  col_n,
  output logic [11:0] key_press,
  output logic        key_valid
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SW = $clog2(DB_CNT + 1);

  col_state_e     state_q, state_d;
  logic [1:0]     col_idx;
  logic [3:0]     row_s;
  logic [CW-1:0]  dwell_q;
  logic           sample, frame_end, same, reached;
  logic [11:0]    snap_q, snap_next, prev_q;
  logic [SW-1:0]  stable_q;
  logic           update_q;

  kp_sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (row_n),
    .q     (row_s)
  );

  assign sample    = (dwell_q == CW'(SCAN_DIV - 1));
  assign col_idx   = state_q;
  assign frame_end = sample && (state_q == COL2);

  // Column sequencer: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= COL0;
    else       state_q <= state_d;
  end

  // Column sequencer: next state, advancing only on the sample cycle
  always_comb begin
    state_d = state_q;
    if (sample) begin
      unique case (state_q)
        COL0:    state_d = COL1;
        COL1:    state_d = COL2;
        default: state_d = COL0;
      endcase
    end
  end

  // Column sequencer: strobe output
  always_comb begin
    col_n = 3'b110;
    unique case (state_q)
      COL1:    col_n = 3'b101;
      COL2:    col_n = 3'b011;
      default: col_n = 3'b110;
    endcase
  end

  // The snapshot including this cycle's column, so frame end sees the full frame.
  always_comb begin
    snap_next = snap_q;
    if (sample) begin
      for (int r = 0; r < 4; r++) begin
        snap_next[key_index(2'(r), col_idx)] = row_s[r];
      end
    end
  end

  assign same = (snap_next == prev_q);
  // A changed frame restarts the count at 1, which already qualifies when DB_CNT is 1.
  assign reached = frame_end &&
                   (same ? (stable_q == SW'(DB_CNT - 1)) : (DB_CNT == 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dwell_q   <= '0;
      snap_q    <= KEY_IDLE;
      prev_q    <= KEY_IDLE;
      stable_q  <= '0;
      update_q  <= 1'b0;
      key_press <= KEY_IDLE;
      key_valid <= 1'b0;
    end else begin
      dwell_q  <= sample ? '0 : dwell_q + 1'b1;
      update_q <= reached;
      if (sample) snap_q <= snap_next;
      if (frame_end) begin
        if (same) begin
          if (stable_q != SW'(DB_CNT)) stable_q <= stable_q + 1'b1;
        end else begin
          prev_q   <= snap_next;
          stable_q <= SW'(1);
        end
      end
      key_valid <= 1'b0;
      if (update_q) begin
        key_press <= single_key(prev_q) ? prev_q : KEY_IDLE;
        key_valid <= (key_press == KEY_IDLE) && single_key(prev_q);
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a physical key matrix driven by a pressed-key mask, and a
// frame-level reference model of the debounced output feeding an expected queue.
module tb_keypad_scan;

  localparam int SCAN_DIV = 4;
  localparam int DB_CNT   = 2;
  localparam int FRAME    = 3 * SCAN_DIV;

  localparam logic [11:0] M_1    = 12'h001;
  localparam logic [11:0] M_3    = 12'h004;
  localparam logic [11:0] M_4    = 12'h008;
  localparam logic [11:0] M_8    = 12'h080;
  localparam logic [11:0] M_STAR = 12'h800;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  row_n;
  logic [2:0]  col_n;
  logic [11:0] key_press;
  logic        key_valid;

  logic [11:0] press_mask;

  int n_tests = 0;
  int n_fail  = 0;
  int k       = 0;
  int kv_count;

  // Reference model state, kept per frame
  logic [11:0] m_prev;
  int          m_stable;
  logic        m_pending;
  logic [11:0] exp_kp;
  logic        exp_kv;
  logic [11:0] last_kp;
  logic [11:0] exp_q[$];
  logic [11:0] obs_q[$];
  logic        recording;

  keypad_scan #(.SCAN_DIV(SCAN_DIV), .DB_CNT(DB_CNT)) dut (
    .clk       (clk),
    .reset     (reset),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_press (key_press),
    .key_valid (key_valid)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  function automatic int key_bit(input int r, input int c);
    int p;
    p = r * 3 + c;
    if (p < 9)  return p;
    if (p == 9) return 11;
    if (p == 10) return 9;
    return 10;
  endfunction

  // Physical matrix: a row reads low when a pressed key joins it to the driven column.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (!col_n[c] && press_mask[key_bit(r, c)]) row_n[r] = 1'b0;
  end

  function automatic logic one_low(input logic [11:0] v);
    return $countones(~v) == 1;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, k);
    end
  endtask

  task automatic model_reset();
    m_prev    = 12'hFFF;
    m_stable  = 0;
    m_pending = 1'b0;
    exp_kv    = 1'b0;
    if (exp_kp !== 12'hFFF) exp_q.push_back(12'hFFF);
    exp_kp    = 12'hFFF;
  endtask

  // Scoreboard: every change of key_press must match the next expected value.
  task automatic check_change();
    logic [11:0] e;
    if (key_press !== last_kp) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_change", {20'd0, key_press}, {20'd0, last_kp});
      end else begin
        e = exp_q.pop_front();
        check_eq("kp_change", {20'd0, key_press}, {20'd0, e});
      end
      if (recording) obs_q.push_back(key_press);
      last_kp = key_press;
    end
  endtask

  task automatic model_frame_end();
    logic [11:0] snap;
    snap = ~press_mask;
    if (snap == m_prev) begin
      if (m_stable < DB_CNT) begin
        m_stable++;
        m_pending = (m_stable == DB_CNT);
      end
    end else begin
      m_prev    = snap;
      m_stable  = 1;
      m_pending = (DB_CNT == 1);
    end
  endtask

  task automatic model_update();
    logic [11:0] nk;
    nk     = one_low(m_prev) ? m_prev : 12'hFFF;
    exp_kv = (exp_kp == 12'hFFF) && (nk != 12'hFFF);
    if (nk != exp_kp) exp_q.push_back(nk);
    exp_kp = nk;
  endtask

  task automatic step_cycle();
    @(posedge clk);
    k++;
    exp_kv = 1'b0;
    if ((k % FRAME) == 1 && m_pending) begin
      model_update();
      m_pending = 1'b0;
    end
    if ((k % FRAME) == 0) model_frame_end();
    @(negedge clk);
    check_eq("col_n", {29'd0, col_n}, {29'd0, ~(3'b001 << ((k / SCAN_DIV) % 3))});
    check_eq("key_press", {20'd0, key_press}, {20'd0, exp_kp});
    check_eq("key_valid", {31'd0, key_valid}, {31'd0, exp_kv});
    if (key_valid) kv_count++;
    check_change();
  endtask

  task automatic run_frames(input logic [11:0] mask, input int n);
    press_mask = mask;
    for (int i = 0; i < n * FRAME; i++) step_cycle();
  endtask

  task automatic expect_obs(input string tag, input logic [11:0] exp_list[$]);
    check_eq({tag, "_len"}, obs_q.size(), exp_list.size());
    for (int i = 0; i < exp_list.size() && i < obs_q.size(); i++)
      check_eq(tag, {20'd0, obs_q[i]}, {20'd0, exp_list[i]});
    obs_q.delete();
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
    k = 0;
  endtask

  initial begin
    logic [11:0] seq_exp[$];
    logic [11:0] keys[4];
    logic [11:0] m;
    reset      = 1'b1;
    press_mask = '0;
    recording  = 1'b0;
    kv_count   = 0;
    exp_kp     = 12'hFFF;
    last_kp    = 12'hFFF;
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("rst_col_n", {29'd0, col_n}, 32'h6);
    check_eq("rst_key_press", {20'd0, key_press}, 32'hFFF);
    check_eq("rst_key_valid", {31'd0, key_valid}, 32'h0);
    release_reset();

    // Idle
    run_frames(12'h000, 3);
    check_eq("idle_kv", kv_count, 0);

    // Hold '4' from frame start
    kv_count = 0;
    run_frames(M_4, 4);
    check_eq("hold4_kv", kv_count, 1);
    check_eq("hold4_kp", {20'd0, key_press}, 32'hFF7);
    run_frames(12'h000, 3);

    // Press sequence '*','4','8','1'
    kv_count  = 0;
    recording = 1'b1;
    keys[0] = M_STAR; keys[1] = M_4; keys[2] = M_8; keys[3] = M_1;
    for (int i = 0; i < 4; i++) begin
      run_frames(keys[i], 3);
      run_frames(12'h000, 3);
    end
    seq_exp = '{12'h7FF, 12'hFFF, 12'hFF7, 12'hFFF, 12'hF7F, 12'hFFF, 12'hFFE, 12'hFFF};
    expect_obs("seq", seq_exp);
    check_eq("seq_kv", kv_count, 4);

    // Bounce on '8'
    kv_count = 0;
    run_frames(M_8, 1);
    run_frames(12'h000, 1);
    run_frames(M_8, 1);
    check_eq("bounce_hold", {20'd0, key_press}, 32'hFFF);
    run_frames(M_8, 2);
    run_frames(12'h000, 3);
    seq_exp = '{12'hF7F, 12'hFFF};
    expect_obs("bounce", seq_exp);
    check_eq("bounce_kv", kv_count, 1);

    // Chord '1'+'3', then release '3'
    kv_count = 0;
    run_frames(M_1 | M_3, 4);
    check_eq("chord_kp", {20'd0, key_press}, 32'hFFF);
    check_eq("chord_kv", kv_count, 0);
    run_frames(M_1, 3);
    check_eq("chord_rel_kp", {20'd0, key_press}, 32'hFFE);
    check_eq("chord_rel_kv", kv_count, 1);
    run_frames(12'h000, 3);
    recording = 1'b0;
    obs_q.delete();

    // Reset mid-frame while '8' is shown
    run_frames(M_8, 3);
    check_eq("pre_rst_kp", {20'd0, key_press}, 32'hF7F);
    for (int i = 0; i < 5; i++) step_cycle();
    #2 reset = 1'b1;
    #1;
    check_eq("async_rst_kp", {20'd0, key_press}, 32'hFFF);
    check_eq("async_rst_col", {29'd0, col_n}, 32'h6);
    check_eq("async_rst_kv", {31'd0, key_valid}, 32'h0);
    model_reset();
    check_change();
    repeat (2) @(negedge clk);
    release_reset();
    kv_count = 0;
    run_frames(M_8, 3);
    check_eq("post_rst_kv", kv_count, 1);
    check_eq("post_rst_kp", {20'd0, key_press}, 32'hF7F);
    run_frames(12'h000, 3);

    // Randomized frames: idle, one key, or a two-key chord
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       m = 12'h000;
        1, 2:    m = 12'h001 << $urandom_range(0, 11);
        default: m = (12'h001 << $urandom_range(0, 11)) | (12'h001 << $urandom_range(0, 11));
      endcase
      run_frames(m, $urandom_range(1, 4));
    end
    run_frames(12'h000, 3);

    check_eq("exp_q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
Scans a 4x3 telephone-style key matrix and produces the 12-bit active-low one-hot key vector that the keypad lock FSM consumes on user_press. Drives one column low at a time and samples the four row lines through a synchronizer. Debounces complete scan frames and rejects multi-key chords. Sits between the board keypad pins and the lock block.

Parameters:
SCAN_DIV, 1000, clock cycles each column is driven before its rows are sampled (>=2)
DB_CNT, 16, consecutive identical frames required before key_press updates (>=1)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-high reset
row_n  input  4  matrix row lines, active-low, asynchronous to clk; row0=1-2-3, row1=4-5-6, row2=7-8-9, row3=*-0-#
col_n  output  3  column strobe, active-low, exactly one bit low at all times; col0=1/4/7/*, col1=2/5/8/0, col2=3/6/9/#
key_press  output  12  debounced key vector, active-low one-hot, 12'hFFF = no key
key_valid  output  1  one-cycle pulse when key_press changes from 12'hFFF to a single key

Behaviour:
- Key bit map (bit low = pressed): digit d in 1..9 -> bit d-1; '0' -> bit 9; '#' -> bit 10; '*' -> bit 11. Examples: '4' = 12'hFF7, '8' = 12'hF7F, '1' = 12'hFFE, '*' = 12'h7FF.
- Reset values: col_n=3'b110, key_press=12'hFFF, key_valid=0. The dwell counter, frame snapshot, previous snapshot, stable counter and synchronizer flops are all cleared: snapshots to 12'hFFF, synchronizer flops to 4'hF.
- row_n passes through a 2-flop synchronizer (sub-module). Only synchronized rows are used.
- Dwell counter counts 0..SCAN_DIV-1 and wraps.
  - On count SCAN_DIV-1, the synchronized rows are written into the snapshot bits of the currently driven column, and col_n rotates 110 -> 101 -> 011 -> 110.
- Frame end is the sample cycle of col2. One frame = 3*SCAN_DIV cycles.
- At frame end, the completed snapshot is compared with the previous snapshot:
  - Equal: the stable counter increments, saturating at DB_CNT.
  - Different: the stable counter is set to 1 and the previous snapshot is replaced.
- When the stable counter reaches DB_CNT (transition edge only), key_press is updated on the next cycle:
  - Snapshot has exactly one low bit: key_press = snapshot.
  - Zero low bits or more than one low bit: key_press = 12'hFFF. A chord is treated as release.
- key_valid asserts in the same cycle key_press goes from 12'hFFF to a one-hot value. It stays low on key-to-key changes without a release and on release.
- Latency: a key held from the start of a frame appears on key_press 1 cycle after the end of frame DB_CNT.
- Boundary conditions:
  - A bounce inside a frame restarts debounce.
  - A key held indefinitely produces no further key_valid.
  - Reset mid-scan returns to col0 with all state cleared, and key_press goes to 12'hFFF immediately (asynchronous).
  - The stable counter never wraps.
- Counter widths are $clog2 of SCAN_DIV and of DB_CNT+1.

Decomposition:
- Package keypad_pkg:
  - KEY_IDLE = 12'hFFF.
  - Key bit index constants KEY_1..KEY_9, KEY_0, KEY_HASH, KEY_STAR.
  - A function giving the key bit index from (row, col).
  - This package is shared with the lock block for secret-number constants.
- One sub-module, kp_sync2: a 4-bit two-flop synchronizer with async active-high reset to 4'hF.

Test Plan (SCAN_DIV=4, DB_CNT=2, frame = 12 cycles):
- Reset, then idle rows = 4'hF:
  - col_n cycles 110/101/011 every 4 cycles.
  - key_press stays 12'hFFF and key_valid stays 0.
- Hold '4' (row1 low while col0 is low) from frame start:
  - key_press = 12'hFF7 one cycle after the 2nd frame end.
  - key_valid pulses exactly once.
- Press sequence '*','4','8','1', each pressed for 3 frames then released for 3 frames:
  - key_press shows 12'h7FF, FFF, FF7, FFF, F7F, FFF, FFE, FFF in order.
  - There are 4 key_valid pulses.
- Bounce: hold '8', toggle it off for one frame inside the debounce window:
  - key_press is not updated until 2 consecutive equal frames follow.
  - No spurious 12'hFFF or other glitch appears.
- Chord: hold '1' and '3' together for 4 frames:
  - key_press stays 12'hFFF and there is no key_valid.
  - After releasing '3', key_press becomes 12'hFFE.
- Assert reset while key_press = 12'hF7F mid-frame:
  - key_press = 12'hFFF and col_n = 3'b110 asynchronously.
  - After deassertion, with the key still held, key_valid pulses again after 2 frames.
